// File: rtl/manta_bus_initiator_pkg.sv
// Shared types, byte constants and hex helpers for the Manta ASCII bus initiator.
package manta_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RSP,
    DONE
  } state_t;

  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_M  = 8'h4D;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_encode(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // ASCII hex digit (either case) to {valid, nibble}.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = 5'b0_0000;
    if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, b[3:0]};
    end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      r = {1'b1, b[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/manta_bus_initiator_if.sv
// Parallel request/response port of the Manta bus initiator.
interface manta_bus_initiator_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/manta_bus_initiator_rsp_parser.sv
// Byte parser for the "M"+hex+CR+LF read-response frame.
// done/err are combinational on the strobe that completes or breaks the frame.
module manta_rsp_parser
  import manta_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DD = DATA_WIDTH / 4;
  localparam int PW = $clog2(DD + 3);

  logic [PW-1:0]         p;
  logic [DATA_WIDTH-1:0] acc;
  logic [4:0]            dec;

  assign rdata = acc;

  // Classify the current byte against the expected position in the frame.
  always_comb begin
    dec  = hex_decode(rx_data);
    done = 1'b0;
    err  = 1'b0;
    if (rx_valid) begin
      if (p == '0) begin
        if (rx_data != CH_M && rx_data != CH_CR && rx_data != CH_LF) begin
          done = 1'b1;
          err  = 1'b1;
        end
      end else if (p <= PW'(DD)) begin
        if (!dec[4]) begin
          done = 1'b1;
          err  = 1'b1;
        end
      end else if (p == PW'(DD + 1)) begin
        if (rx_data != CH_CR) begin
          done = 1'b1;
          err  = 1'b1;
        end
      end else begin
        done = 1'b1;
        err  = (rx_data != CH_LF);
      end
    end
  end

  // Advance the position and shift hex digits into the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p   <= '0;
      acc <= '0;
    end else if (start) begin
      p   <= '0;
      acc <= '0;
    end else if (rx_valid && !done) begin
      if (p == '0) begin
        if (rx_data == CH_M) p <= PW'(1);
      end else begin
        if (p <= PW'(DD)) acc <= (acc << 4) | DATA_WIDTH'(dec[3:0]);
        p <= p + PW'(1);
      end
    end
  end

endmodule

// File: rtl/manta_bus_initiator.sv
// Manta ASCII bus initiator: serialises requests into tx frames and
// collects read responses from rx, one transaction at a time.
module manta_bus_initiator
  import manta_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  manta_bus_initiator_if.slave  bus,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  busy
);

  localparam int AD = ADDR_WIDTH / 4;
  localparam int DD = DATA_WIDTH / 4;
  localparam int SW = ADDR_WIDTH + DATA_WIDTH;
  localparam int IW = $clog2(AD + DD + 3);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t                state;
  logic                  rw_q;
  logic [SW-1:0]         sh;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         ndig;
  logic [TW-1:0]         tmo;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  tx_hs;
  logic                  last_byte;
  logic                  p_start;
  logic                  p_done;
  logic                  p_err;
  logic [DATA_WIDTH-1:0] p_rdata;

  assign ndig          = rw_q ? IW'(AD + DD) : IW'(AD);
  assign tx_valid      = (state == SEND);
  assign tx_hs         = tx_valid & tx_ready;
  assign last_byte     = (idx == ndig + IW'(2));
  assign p_start       = tx_hs & last_byte & ~rw_q;
  assign busy          = (state != IDLE);
  assign bus.req_ready = (state == IDLE) & ~rst;
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Frame byte mux: command letter, hex digits from the top of the shifter, CR, LF.
  always_comb begin
    tx_data = 8'h00;
    if (state == SEND) begin
      if (idx == '0)                  tx_data = rw_q ? CH_W : CH_R;
      else if (idx <= ndig)           tx_data = hex_encode(sh[SW-1 -: 4]);
      else if (idx == ndig + IW'(1))  tx_data = CH_CR;
      else                            tx_data = CH_LF;
    end
  end

  manta_rsp_parser #(.DATA_WIDTH(DATA_WIDTH)) u_parser (
    .clk      (clk),
    .rst      (rst),
    .start    (p_start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid && (state == WAIT_RSP)),
    .done     (p_done),
    .err      (p_err),
    .rdata    (p_rdata)
  );

  // Transaction FSM with request latch, byte index and response timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rw_q    <= 1'b0;
      sh      <= '0;
      idx     <= '0;
      tmo     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          if (bus.req_valid) begin
            rw_q  <= bus.req_rw;
            sh    <= {bus.req_addr, bus.req_wdata};
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (tx_hs) begin
            idx <= idx + IW'(1);
            if (idx != '0 && idx <= ndig) sh <= sh << 4;
            if (last_byte) begin
              tmo   <= '0;
              state <= rw_q ? DONE : WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (p_done) begin
            err_q   <= p_err;
            rdata_q <= p_err ? '0 : p_rdata;
            state   <= DONE;
          end else if (TIMEOUT_CYCLES != 0 && tmo == TW'(TIMEOUT_CYCLES)) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= DONE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        DONE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
